ghost_scheduler: RTL and testbench
==================================

# ghost_scheduler

Time-multiplexes one shared ghost direction engine across `NUM_GHOSTS` ghosts. The engine is the `ghost_control` instance, with `slower_clk` tied to `clk`. On each game tick the block presents every ghost's position and previous direction to the engine in turn and waits the engine latency. It then captures the chosen direction and advances that ghost one step. It sits between the frame-tick generator and the renderer, and owns all ghost position and direction state.

## Interface
- `NUM_GHOSTS`, 4: ghosts served per round (1–8).
- `LAT`, 3: engine latency in `clk` cycles, from stable `sel_*` to valid `engine_dir` (≥1).
- `STEP`, 1: pixels moved per committed step.
- `HOME_X`, 304: reset x of ghost 0; ghost i = `HOME_X` + 16·i.
- `HOME_Y`, 240: reset y of all ghosts.
- `X_MAX`, 639: rightmost x (horizontal tunnel wrap point).
- `Y_MAX`, 479: bottom y.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle game-tick strobe.
- `pacman_pos_x` in 11, `pacman_pos_y` in 10: pacman position for catch detection.
- `engine_dir` in 4: `move_direction` from the shared engine.
- `sel_ghost_x` out 11, `sel_ghost_y` out 10, `sel_prev_dir` out 4: drive the engine's ghost position and `prev_direction` inputs.
- `ghost_x_flat` out 11·N, `ghost_y_flat` out 10·N, `ghost_dir_flat` out 4·N: per-ghost state. Ghost i occupies slice [i·W +: W].
- `busy` out 1: round in progress.
- `round_done` out 1: one-cycle pulse after the last commit.
- `caught_mask` out N: bit i set when ghost i lands on pacman this round.
- `overrun_cnt` out 8: saturating count of dropped ticks.

## Operation
- Direction encoding is one-hot:
  - RIGHT = 0001
  - UP = 0010
  - DOWN = 0100
  - LEFT = 1000
  - 0000 = none
- States: IDLE, SETTLE, COMMIT. `idx` is a 3-bit register; `cnt` is a down-counter.
- IDLE: `busy`=0 and `idx`=0. On `tick`, go to SETTLE with `cnt`=`LAT`−1 and clear `caught_mask`.
- SETTLE: `busy`=1. Decrement `cnt`; when `cnt`=0, go to COMMIT.
- COMMIT: `busy`=1. Capture `engine_dir` into ghost[idx]:
  - One-hot `engine_dir`: `dir`←`engine_dir` and position moves by `STEP`.
    - RIGHT: x+`STEP`. Past `X_MAX`, x wraps to x−`X_MAX`−1.
    - LEFT: x−`STEP`. Below 0, x wraps to `X_MAX`+1+(x−`STEP`).
    - UP: y−`STEP`, saturating at 0.
    - DOWN: y+`STEP`, saturating at `Y_MAX`.
  - `engine_dir` zero or not one-hot: position unchanged, `dir`←0000.
  - Catch check: if the new position equals (`pacman_pos_x`, `pacman_pos_y`), set `caught_mask`[idx].
  - If `idx`=N−1: go to IDLE, pulse `round_done`, `idx`←0.
  - Otherwise: `idx`←`idx`+1, go to SETTLE with `cnt`=`LAT`−1.
- `sel_*` are combinational from ghost[`idx`] in all states. They therefore stay stable for all `LAT` SETTLE cycles of each ghost.
- A `tick` while `busy`=1 is dropped and `overrun_cnt` increments, saturating at 255. A `tick` in the IDLE cycle that carries `round_done` is accepted.
- Every round processes ghosts strictly in order 0..N−1. No ghost is skipped and none is served twice.

## Timing
- Reset values:
  - ghost i: x=`HOME_X`+16i, y=`HOME_Y`, dir=0000.
  - `busy`=0, `round_done`=0, `caught_mask`=0, `overrun_cnt`=0, `idx`=0, state IDLE.
- Asserting `rst` mid-round abandons the round. All state, including already-moved ghosts, returns to reset values at the next edge.
- `tick` sampled in IDLE at edge t0: `busy`=1 from t0+1.
- Ghost i position/dir update at edge t0+(i+1)(`LAT`+1).
- `round_done`=1 for exactly the cycle after the final commit, i.e. from edge t0+N(`LAT`+1).
- `busy` is high for N(`LAT`+1) cycles per round. Default round length is 16 cycles.
- `engine_dir` is sampled only in COMMIT. Its value in other cycles is ignored.

## Test plan
- Reset, then `tick` with `engine_dir`=0001 constant → `busy` high 16 cycles, then `round_done` 1 cycle. Ghost x = 305, 321, 337, 353; dirs all 0001.
- Ghost 0 at x=639 with RIGHT → x=0. A second ghost at x=0 with LEFT → x=639. A ghost at y=0 with UP → y stays 0.
- `engine_dir`=0011 at commit → position unchanged, dir=0000.
- `tick` pulsed at round start +5 and +10 → both dropped, `overrun_cnt`=2, round completes normally. A `tick` coincident with `round_done` starts a new round at once.
- Pacman at (305,240) with RIGHT for ghost 0 → `caught_mask`=0001 after commit 0. The mask clears on the next accepted `tick`.
- `rst` pulsed during ghost 2 SETTLE → next cycle all ghosts at home positions, `busy`=0, no `round_done`.

Source files
------------

// File: rtl/ghost_scheduler.sv
// Shares one ghost direction engine across NUM_GHOSTS ghosts: each game tick walks the ghosts
// in order, lets the engine settle on the selected ghost, then commits its direction and step.
module ghost_scheduler #(
  parameter int unsigned NUM_GHOSTS = 4,
  parameter int unsigned LAT        = 3,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOME_X     = 304,
  parameter int unsigned HOME_Y     = 240,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [10:0]              pacman_pos_x,
  input  logic [9:0]               pacman_pos_y,
  input  logic [3:0]               engine_dir,
  output logic [10:0]              sel_ghost_x,
  output logic [9:0]               sel_ghost_y,
  output logic [3:0]               sel_prev_dir,
  output logic [11*NUM_GHOSTS-1:0] ghost_x_flat,
  output logic [10*NUM_GHOSTS-1:0] ghost_y_flat,
  output logic [4*NUM_GHOSTS-1:0]  ghost_dir_flat,
  output logic                     busy,
  output logic                     round_done,
  output logic [NUM_GHOSTS-1:0]    caught_mask,
  output logic [7:0]               overrun_cnt
);

  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [3:0] DirRight = 4'b0001;
  localparam logic [3:0] DirUp    = 4'b0010;
  localparam logic [3:0] DirDown  = 4'b0100;
  localparam logic [3:0] DirLeft  = 4'b1000;

  typedef enum logic [1:0] {StIdle, StSettle, StCommit} state_e;

  state_e                  state_q;
  logic [2:0]              idx_q;
  logic [CntW-1:0]         cnt_q;
  logic                    busy_q;
  logic                    round_done_q;
  logic [NUM_GHOSTS-1:0]   caught_q;
  logic [7:0]              overrun_q;
  logic [10:0]             gx_q [NUM_GHOSTS];
  logic [9:0]              gy_q [NUM_GHOSTS];
  logic [3:0]              gd_q [NUM_GHOSTS];

  logic [10:0]             commit_x_d;
  logic [9:0]              commit_y_d;
  logic [3:0]              commit_dir_d;
  logic                    hit_d;

  // Selected ghost is a pure mux on idx so the engine sees stable inputs throughout SETTLE.
  always_comb begin
    sel_ghost_x  = '0;
    sel_ghost_y  = '0;
    sel_prev_dir = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (idx_q == 3'(i)) begin
        sel_ghost_x  = gx_q[i];
        sel_ghost_y  = gy_q[i];
        sel_prev_dir = gd_q[i];
      end
    end
  end

  always_comb begin
    commit_x_d   = sel_ghost_x;
    commit_y_d   = sel_ghost_y;
    commit_dir_d = '0;
    unique case (engine_dir)
      DirRight: begin
        commit_dir_d = DirRight;
        if (32'(sel_ghost_x) + STEP > X_MAX) begin
          commit_x_d = 11'(32'(sel_ghost_x) + STEP - X_MAX - 1);
        end else begin
          commit_x_d = 11'(32'(sel_ghost_x) + STEP);
        end
      end
      DirLeft: begin
        commit_dir_d = DirLeft;
        if (32'(sel_ghost_x) < STEP) begin
          commit_x_d = 11'(X_MAX + 1 + 32'(sel_ghost_x) - STEP);
        end else begin
          commit_x_d = 11'(32'(sel_ghost_x) - STEP);
        end
      end
      DirUp: begin
        commit_dir_d = DirUp;
        if (32'(sel_ghost_y) < STEP) begin
          commit_y_d = '0;
        end else begin
          commit_y_d = 10'(32'(sel_ghost_y) - STEP);
        end
      end
      DirDown: begin
        commit_dir_d = DirDown;
        if (32'(sel_ghost_y) + STEP > Y_MAX) begin
          commit_y_d = 10'(Y_MAX);
        end else begin
          commit_y_d = 10'(32'(sel_ghost_y) + STEP);
        end
      end
      default: ;
    endcase
    hit_d = (commit_x_d == pacman_pos_x) && (commit_y_d == pacman_pos_y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      caught_q     <= '0;
      overrun_q    <= '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        gx_q[i] <= 11'(HOME_X + 16 * i);
        gy_q[i] <= 10'(HOME_Y);
        gd_q[i] <= '0;
      end
    end else begin
      round_done_q <= 1'b0;
      if (tick && busy_q && overrun_q != 8'hFF) begin
        overrun_q <= overrun_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_q  <= StSettle;
            cnt_q    <= CntW'(LAT - 1);
            busy_q   <= 1'b1;
            caught_q <= '0;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StCommit;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCommit: begin
          for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (idx_q == 3'(i)) begin
              gx_q[i] <= commit_x_d;
              gy_q[i] <= commit_y_d;
              gd_q[i] <= commit_dir_d;
              if (hit_d) begin
                caught_q[i] <= 1'b1;
              end
            end
          end
          if (idx_q == 3'(NUM_GHOSTS - 1)) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            round_done_q <= 1'b1;
          end else begin
            state_q <= StSettle;
            idx_q   <= idx_q + 3'd1;
            cnt_q   <= CntW'(LAT - 1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_flat
    assign ghost_x_flat[11*g +: 11]  = gx_q[g];
    assign ghost_y_flat[10*g +: 10]  = gy_q[g];
    assign ghost_dir_flat[4*g +: 4]  = gd_q[g];
  end

  assign busy        = busy_q;
  assign round_done  = round_done_q;
  assign caught_mask = caught_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_ghost_scheduler.sv
// Scoreboarded bench for ghost_scheduler: rounds push expected ghost state, a monitor pops
// and compares it on every round_done pulse and also checks each busy window's length.
module tb_ghost_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [10:0]   px;
  logic [9:0]    py;
  logic [3:0]    edir;
  logic [10:0]   sel_x;
  logic [9:0]    sel_y;
  logic [3:0]    sel_d;
  logic [11*N-1:0] gxf;
  logic [10*N-1:0] gyf;
  logic [4*N-1:0]  gdf;
  logic          busy;
  logic          round_done;
  logic [N-1:0]  caught_mask;
  logic [7:0]    overrun_cnt;

  ghost_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .pacman_pos_x  (px),
    .pacman_pos_y  (py),
    .engine_dir    (edir),
    .sel_ghost_x   (sel_x),
    .sel_ghost_y   (sel_y),
    .sel_prev_dir  (sel_d),
    .ghost_x_flat  (gxf),
    .ghost_y_flat  (gyf),
    .ghost_dir_flat(gdf),
    .busy          (busy),
    .round_done    (round_done),
    .caught_mask   (caught_mask),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11*N-1:0] xf;
    logic [10*N-1:0] yf;
    logic [4*N-1:0]  df;
    logic [N-1:0]    cm;
    logic [7:0]      ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  int   mx [N];
  int   my [N];
  logic [3:0] md [N];
  int   mov;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 304 + 16 * i;
      my[i] = 240;
      md[i] = 4'b0000;
    end
    mov = 0;
  endtask

  task automatic mstep(input int i, input logic [3:0] d);
    md[i] = d;
    case (d)
      4'b0001: begin mx[i] = mx[i] + 1; if (mx[i] > 639) mx[i] = mx[i] - 640; end
      4'b1000: begin mx[i] = mx[i] - 1; if (mx[i] < 0) mx[i] = mx[i] + 640; end
      4'b0010: my[i] = (my[i] == 0) ? 0 : my[i] - 1;
      4'b0100: my[i] = (my[i] == 479) ? 479 : my[i] + 1;
      default: md[i] = 4'b0000;
    endcase
  endtask

  // dirs[4i+:4] is what the engine reports for ghost i; extra adds ticks at round cycles 5/10.
  task automatic run_round(input logic [15:0] dirs, input bit extra);
    exp_t e;
    e.cm = '0;
    for (int i = 0; i < N; i++) begin
      mstep(i, dirs[4*i +: 4]);
      e.cm[i] = (mx[i] == int'(px)) && (my[i] == int'(py));
      e.xf[11*i +: 11] = 11'(mx[i]);
      e.yf[10*i +: 10] = 10'(my[i]);
      e.df[4*i +: 4]   = md[i];
    end
    if (extra) mov = (mov + 2 > 255) ? 255 : mov + 2;
    e.ov = 8'(mov);
    sb_q.push_back(e);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk("busy_after_tick", busy, 1);
    chk("caught_cleared_on_tick", caught_mask, 0);
    for (int k = 0; k < 16; k++) begin
      edir = dirs[4*(k/4) +: 4];
      tick = extra && (k == 5 || k == 10);
      @(posedge clk); #1;
    end
    tick = 1'b0;
  endtask

  int bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      else if (bcnt != 0) begin
        chk("busy_len", bcnt, 16);
        bcnt = 0;
      end
      if (round_done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_round_done", round_done, 0);
        end else begin
          e = sb_q.pop_front();
          for (int i = 0; i < N; i++) begin
            chk($sformatf("sb_g%0d_x", i), gxf[11*i +: 11], e.xf[11*i +: 11]);
            chk($sformatf("sb_g%0d_y", i), gyf[10*i +: 10], e.yf[10*i +: 10]);
            chk($sformatf("sb_g%0d_dir", i), gdf[4*i +: 4], e.df[4*i +: 4]);
          end
          chk("sb_caught", caught_mask, e.cm);
          chk("sb_overrun", overrun_cnt, e.ov);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    edir = 4'b0000;
    px   = 11'd305;
    py   = 10'd240;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_g%0d_x", i), gxf[11*i +: 11], 304 + 16 * i);
      chk($sformatf("rst_g%0d_y", i), gyf[10*i +: 10], 240);
      chk($sformatf("rst_g%0d_dir", i), gdf[4*i +: 4], 0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_round_done", round_done, 0);
    chk("rst_caught", caught_mask, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_sel_x", sel_x, 304);
    chk("rst_sel_dir", sel_d, 0);

    // All RIGHT; pacman sits where ghost 0 lands.
    run_round(16'h1111, 1'b0);
    chk("a_round_done", round_done, 1);
    chk("a_g0_x", gxf[0 +: 11], 305);
    chk("a_g1_x", gxf[11 +: 11], 321);
    chk("a_g2_x", gxf[22 +: 11], 337);
    chk("a_g3_x", gxf[33 +: 11], 353);
    chk("a_g3_dir", gdf[12 +: 4], 1);
    chk("a_caught", caught_mask, 4'b0001);

    // Non-one-hot engine output: hold position, clear direction.
    px = 11'd700;
    run_round(16'h3333, 1'b0);
    chk("b_g0_x", gxf[0 +: 11], 305);
    chk("b_g0_dir", gdf[0 +: 4], 0);

    // Two ticks during a busy round are dropped.
    run_round(16'h1111, 1'b1);
    chk("c_overrun", overrun_cnt, 2);
    chk("c_g1_x", gxf[11 +: 11], 322);

    // Issued in the round_done cycle: must start immediately.
    run_round(16'h8888, 1'b0);
    chk("d_g2_x", gxf[22 +: 11], 337);

    // Reset during ghost 2 SETTLE abandons the round.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    edir = 4'b0001;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("r_g0_x", gxf[0 +: 11], 304);
    chk("r_g1_x", gxf[11 +: 11], 320);
    chk("r_g0_dir", gdf[0 +: 4], 0);
    chk("r_busy", busy, 0);
    chk("r_overrun", overrun_cnt, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("r_idle_busy", busy, 0);

    // Long walk: g0 RIGHT, g1 LEFT, g2 UP, g3 DOWN, to reach every edge case.
    repeat (320) run_round(16'h4281, 1'b0);
    chk("w_g1_x_zero", gxf[11 +: 11], 0);
    run_round(16'h4281, 1'b0);
    chk("w_g1_x_wrap", gxf[11 +: 11], 639);
    repeat (14) run_round(16'h4281, 1'b0);
    chk("w_g0_x_max", gxf[0 +: 11], 639);
    run_round(16'h4281, 1'b0);
    chk("w_g0_x_wrap", gxf[0 +: 11], 0);
    chk("w_g2_y_sat", gyf[20 +: 10], 0);
    chk("w_g3_y_sat", gyf[30 +: 10], 479);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
